sbox_pipe_multi: RTL and testbench
==================================

// Module: sbox_pipe_multi
// PURPOSE
//  Multi-lane, pipelined AES S-box engine: full SubBytes (GF(2^8) inverse + affine) and InvSubBytes.
//  Processes LANES independent bytes per beat with a valid/ready handshake.
//  Sits between round-state registers and ShiftRows in the AES datapath.
//  Elastic pipeline: one beat per cycle sustained, backpressure-safe.
// PARAMETERS
//  LANES        4   bytes per beat (1..16); data width = 8*LANES
//  PIPE_STAGES  2   register stages (1..4); latency in cycles
// PORTS
//  clk     in   1        clock, rising edge
//  rst     in   1        asynchronous reset, active-low (0 = reset)
//  idata   in   8*LANES  input bytes; lane i = idata[8i+7:8i]
//  imode   in   1        0 = forward S-box, 1 = inverse S-box; sampled with idata
//  ivalid  in   1        upstream beat valid
//  iready  out  1        engine accepts a beat this cycle
//  odata   out  8*LANES  substituted bytes, lane order preserved
//  ovalid  out  1        odata valid
//  oready  in   1        downstream accepts odata
// BEHAVIOUR
//  Reset (rst=0, async assert, sync deassert by system): all stage valids=0, stage data=0;
//   odata=0, ovalid=0, iready=1 (combinational from empty pipe).
//  Transfer rules: input beat accepted when ivalid&iready; output consumed when ovalid&oready.
//  Stage k (0..PIPE_STAGES-1) holds v[k], data, mode. rdy[N]=oready; rdy[k]=~v[k]|rdy[k+1].
//   iready=rdy[0]; ovalid=v[N-1]; odata=stage N-1 data. Stage loads when rdy[k]; else holds.
//  Latency PIPE_STAGES cycles from accept to ovalid when unstalled; throughput 1 beat/cycle.
//  Holding: while ovalid&~oready, odata and ovalid stable; no beat dropped, duplicated or reordered.
//  Full: all stages valid and oready=0 -> iready=0 same cycle. Simultaneous pop/push when full: allowed.
//  ivalid with iready=0: nothing captured; upstream must hold.
//  Forward lane: x' = inv(x) (inv(0)=0, poly 0x11B); s = x'^rotl1^rotl2^rotl3^rotl4 ^ 0x63.
//  Inverse lane: y = rotl1(x)^rotl3(x)^rotl6(x)^0x05; s = inv(y).
//  Split: stage 0 = pre-affine (inverse mode) + GF inversion; last stage = post-affine (fwd).
//   With PIPE_STAGES>2 extra stages are plain register slices after inversion. PIPE_STAGES=1: all in stage 0.
//  imode travels per beat; mixed modes in consecutive beats are legal and independent.
//  All lanes share one valid/ready; lanes have no cross-lane logic. Rotations are 8-bit, mod-2 XOR.
//  Reset mid-operation: in-flight beats discarded, ovalid drops immediately (async), no output after release.
// CONFIGURATION
//  SBOX_PERF_CNT_EN defined: extra port beat_cnt out 32: counts output handshakes (ovalid&oready);
//   reset to 0, wraps 0xFFFFFFFF->0, increments by 1 per transfer.
//  Not defined: port and counter absent; datapath identical.
// TESTING
//  Fwd known vectors, LANES=4: idata=32'h0001_0253, imode=0 -> odata=32'h637C_77ED after 2 cycles.
//  Inv vectors: idata=32'h637C_77ED, imode=1 -> odata=32'h0001_0253; alternate modes each beat, all match.
//  Exhaustive: 0x00..0xFF every lane, fwd then inv of result -> original byte; fwd(0x00)=0x63.
//  Backpressure: oready=0, push 3 beats (PIPE_STAGES=2) -> 2 accepted, iready=0; oready=1 -> 3 out in order.
//  Throughput: ivalid=oready=1 for 256 beats -> all out in 256+PIPE_STAGES cycles, no bubbles.
//  Reset mid-stream: rst=0 with 2 in flight -> ovalid=0, odata=0 at once; after release iready=1, no stale beat.

Source files
------------

// File: rtl/sbox_pipe_multi.sv
// rtl/sbox_pipe_multi.sv - multi-lane elastic AES S-box pipeline (SubBytes / InvSubBytes)
// Optional feature macro: SBOX_PERF_CNT_EN adds the beat_cnt output-handshake counter port.
module sbox_pipe_multi #(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SBOX_PERF_CNT_EN
  output logic [31:0]          beat_cnt,
`endif
  input  logic [8*LANES-1:0]   idata,
  input  logic                 imode,
  input  logic                 ivalid,
  output logic                 iready,
  output logic [8*LANES-1:0]   odata,
  output logic                 ovalid,
  input  logic                 oready
);

  localparam int W = 8 * LANES;
  localparam int N = PIPE_STAGES;

  // 8-bit rotate left by n (0..7).
  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} >> (8 - n);
    return t[7:0];
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(x, x);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Forward affine transform applied after inversion.
  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  // Inverse affine transform applied before inversion.
  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
  endfunction

  // Front half of every lane: optional pre-affine (inverse mode) then GF inversion.
  function automatic logic [W-1:0] front_word(input logic [W-1:0] d, input logic m);
    logic [W-1:0] r;
    logic [7:0]   y;
    for (int i = 0; i < LANES; i++) begin
      y = m ? inv_affine(d[8*i +: 8]) : d[8*i +: 8];
      r[8*i +: 8] = gf_inv(y);
    end
    return r;
  endfunction

  // Back half of every lane: post-affine in forward mode, pass-through in inverse mode.
  function automatic logic [W-1:0] back_word(input logic [W-1:0] d, input logic m);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) begin
      r[8*i +: 8] = m ? d[8*i +: 8] : fwd_affine(d[8*i +: 8]);
    end
    return r;
  endfunction

  logic         v_q    [N];
  logic         mode_q [N];
  logic [W-1:0] data_q [N];
  logic         v_d    [N];
  logic         mode_d [N];
  logic [W-1:0] data_d [N];

  logic         rdy     [N+1];
  logic         in_v    [N];
  logic         in_mode [N];
  logic [W-1:0] in_data [N];

  // Ready chain: a stage may load if it or any stage downstream of it is empty, or the sink pops.
  always_comb begin
    logic all_v;
    all_v  = 1'b1;
    rdy[N] = oready;
    for (int k = N - 1; k >= 0; k--) begin
      all_v  = all_v & v_q[k];
      rdy[k] = oready | ~all_v;
    end
  end

  // Stage inputs: inversion lands in stage 0, post-affine feeds the last stage, middle stages copy.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      in_v[k]    = 1'b0;
      in_mode[k] = 1'b0;
      in_data[k] = '0;
    end
    in_v[0]    = ivalid;
    in_mode[0] = imode;
    if (N == 1) begin
      in_data[0] = back_word(front_word(idata, imode), imode);
    end else begin
      in_data[0] = front_word(idata, imode);
    end
    for (int k = 1; k < N; k++) begin
      in_v[k]    = v_q[k-1];
      in_mode[k] = mode_q[k-1];
      in_data[k] = (k == N - 1) ? back_word(data_q[k-1], mode_q[k-1]) : data_q[k-1];
    end
  end

  // Next state: each stage loads its upstream value when ready, otherwise holds.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      v_d[k]    = rdy[k] ? in_v[k]    : v_q[k];
      mode_d[k] = rdy[k] ? in_mode[k] : mode_q[k];
      data_d[k] = rdy[k] ? in_data[k] : data_q[k];
    end
  end

  // Stage registers; async reset empties and zeroes the whole pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        v_q[k]    <= 1'b0;
        mode_q[k] <= 1'b0;
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        v_q[k]    <= v_d[k];
        mode_q[k] <= mode_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  assign iready = rdy[0];
  assign ovalid = v_q[N-1];
  assign odata  = data_q[N-1];

`ifdef SBOX_PERF_CNT_EN
  logic [31:0] beat_cnt_q;
  logic [31:0] beat_cnt_d;

  // Count output handshakes, wrapping naturally at 2^32.
  always_comb begin
    beat_cnt_d = (ovalid && oready) ? beat_cnt_q + 32'd1 : beat_cnt_q;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) beat_cnt_q <= 32'd0;
    else      beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_sbox_pipe_multi.sv
// tb/tb_sbox_pipe_multi.sv - scoreboard bench for sbox_pipe_multi
module tb_sbox_pipe_multi;
  localparam int LANES       = 4;
  localparam int PIPE_STAGES = 2;
  localparam int W           = 8 * LANES;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] idata = '0;
  logic         imode = 1'b0;
  logic         ivalid = 1'b0;
  logic         oready = 1'b0;
  logic         iready;
  logic         ovalid;
  logic [W-1:0] odata;
`ifdef SBOX_PERF_CNT_EN
  logic [31:0]  beat_cnt;
`endif

  always #5 clk = ~clk;

  sbox_pipe_multi #(.LANES(LANES), .PIPE_STAGES(PIPE_STAGES)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef SBOX_PERF_CNT_EN
    .beat_cnt(beat_cnt),
`endif
    .idata  (idata),
    .imode  (imode),
    .ivalid (ivalid),
    .iready (iready),
    .odata  (odata),
    .ovalid (ovalid),
    .oready (oready)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference tables built from GF(2^8) arithmetic by brute-force inverse search.
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic int rot(input int v, input int n);
    return ((v << n) | (v >> (8 - n))) & 255;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      int xi;
      int s;
      xi = 0;
      for (int y = 1; y < 256; y++) if (gmul(x[7:0], y[7:0]) == 8'h01) xi = y;
      s = xi ^ rot(xi, 1) ^ rot(xi, 2) ^ rot(xi, 3) ^ rot(xi, 4) ^ 'h63;
      fwd_tab[x] = s[7:0];
      inv_tab[s] = x[7:0];
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic m);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[8*i +: 8] = m ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
    return r;
  endfunction

  typedef struct {
    logic [W-1:0] d;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  bit           lat_check = 1'b0;
  bit           rand_ready = 1'b0;
  int           last_out_cyc = 0;
  int           n_out = 0;
  int           acc_cyc = 0;
  bit           hold_prev = 1'b0;
  logic [W-1:0] hold_data = '0;

  // Monitor: pops and compares on every output handshake; also checks stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (hold_prev) begin
        check("hold_ovalid", {31'd0, ovalid}, 32'd1);
        check("hold_odata", odata, hold_data);
      end
      if (ovalid && oready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h want no beat (cycle %0d)", odata, cyc);
        end else begin
          e = sb.pop_front();
          check("odata", odata, e.d);
          if (lat_check) check("latency", cyc - e.cyc, PIPE_STAGES);
          n_out++;
          last_out_cyc = cyc;
        end
      end
      hold_prev = ovalid && !oready;
      hold_data = odata;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Random downstream backpressure when enabled.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      oready = ($urandom_range(0, 2) != 0);
    end
  end

  // Present one beat and hold it until accepted; expected value pushed at acceptance.
  task automatic send_exp(input logic [W-1:0] d, input logic m, input logic [W-1:0] exp);
    bit   done;
    exp_t e;
    done   = 1'b0;
    idata  = d;
    imode  = m;
    ivalid = 1'b1;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      if (iready) begin
        e.d   = exp;
        e.cyc = cyc;
        sb.push_back(e);
        acc_cyc = cyc;
        done    = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept want accept within 500 cycles");
      ivalid = 1'b0;
    end
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic m);
    send_exp(d, m, model(d, m));
  endtask

  task automatic idle(input int n);
    ivalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int limit);
    int t;
    t = 0;
    ivalid = 1'b0;
    while (sb.size() != 0 && t < limit) begin
      @(posedge clk);
      t++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_acc;
    int out0;
    logic [W-1:0] d;
    logic [W-1:0] c;

    build_tables();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ovalid", {31'd0, ovalid}, 32'd0);
    check("rst_odata", odata, 32'd0);
    check("rst_iready", {31'd0, iready}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Known vectors, alternating modes
    oready    = 1'b1;
    lat_check = 1'b1;
    send_exp(32'h0001_0253, 1'b0, 32'h637C_77ED);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      send_exp(32'h637C_77ED, 1'b1, 32'h0001_0253);
      send_exp(32'h0001_0253, 1'b0, 32'h637C_77ED);
    end
    drain(100);

    // Every byte value in every lane, forward then inverse of the forward result
    for (int b = 0; b < 256; b++) begin
      d = {b[7:0], b[7:0] ^ 8'h55, ~b[7:0], b[7:0] + 8'd37};
      send_beat(d, 1'b0);
      send_exp(model(d, 1'b0), 1'b1, d);
    end
    drain(100);

    // Throughput: 256 back-to-back beats, no bubbles
    out0 = n_out;
    send_beat($urandom, 1'($urandom_range(0, 1)));
    first_acc = acc_cyc;
    for (int i = 1; i < 256; i++) send_beat($urandom, 1'($urandom_range(0, 1)));
    drain(100);
    check("tput_count", n_out - out0, 256);
    check("tput_span", last_out_cyc - first_acc, 255 + PIPE_STAGES);

    // Backpressure: two beats fill the pipe, third stalls until the sink pops
    lat_check = 1'b0;
    oready    = 1'b0;
    send_beat(32'hA5A5_0000, 1'b0);
    send_beat(32'h1234_5678, 1'b1);
    c = 32'hFFEE_0011;
    fork
      send_beat(c, 1'b0);
      begin
        repeat (3) @(negedge clk);
        check("bp_iready", {31'd0, iready}, 32'd0);
        check("bp_ovalid", {31'd0, ovalid}, 32'd1);
        @(posedge clk);
        #1;
        oready = 1'b1;
      end
    join
    drain(100);

    // Random data, modes, gaps and backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send_beat($urandom, 1'($urandom_range(0, 1)));
    end
    ivalid     = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    oready = 1'b1;
    drain(2000);

    // Reset with two beats in flight
    oready = 1'b0;
    send_beat(32'h0102_0304, 1'b0);
    send_beat(32'h0506_0708, 1'b1);
    ivalid = 1'b0;
    @(negedge clk);
    check("pre_rst_ovalid", {31'd0, ovalid}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_ovalid", {31'd0, ovalid}, 32'd0);
    check("midrst_odata", odata, 32'd0);
    check("midrst_iready", {31'd0, iready}, 32'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    oready = 1'b1;
    check("post_rst_iready", {31'd0, iready}, 32'd1);
    repeat (10) begin
      @(negedge clk);
      check("post_rst_ovalid", {31'd0, ovalid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
